// File: rtl/pipe_stage_ctrl_pkg.sv
// pipe_stage_ctrl_pkg: shared control-state encodings and enable levels for the pipeline controller
package pipe_stage_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_STALL_LU = 2'd1,
    CTRL_FREEZE   = 2'd2,
    CTRL_FLUSH    = 2'd3
  } ctrl_state_e;
  localparam logic FUN_ENABLE  = 1'b1;
  localparam logic FUN_DISABLE = 1'b0;
endpackage

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// sat_counter: saturating event counter, sticks at all-ones
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (inc && ~&count) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: per-stage write enables and valid/bubble tracking for the 5-stage core
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_continue,
  input  logic                 ifid_continue,
  input  logic                 idex_continue,
  input  logic                 branch_flush,
  input  logic                 mem_busy,
  output logic                 pc_wena,
  output logic                 ifid_wena,
  output logic                 idex_wena,
  output logic                 exmem_wena,
  output logic                 memwb_wena,
  output logic                 ifid_valid,
  output logic                 idex_valid,
  output logic                 exmem_valid,
  output logic                 memwb_valid,
  output logic                 retire,
  output logic [1:0]           ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);
  ctrl_state_e state, act;
  logic lu_stall, front_en, back_en;
  // The action is decided from this cycle's inputs; state only records it for debug.
  always_comb begin
    lu_stall = ~(pc_continue & ifid_continue & idex_continue);
    act      = mem_busy ? CTRL_FREEZE : branch_flush ? CTRL_FLUSH : lu_stall ? CTRL_STALL_LU : CTRL_RUN;
    front_en = ~rst & (act == CTRL_RUN || act == CTRL_FLUSH) ? FUN_ENABLE : FUN_DISABLE;
    back_en  = ~rst & (act != CTRL_FREEZE) ? FUN_ENABLE : FUN_DISABLE;
  end
  assign pc_wena    = front_en;
  assign ifid_wena  = front_en;
  assign idex_wena  = back_en;
  assign exmem_wena = back_en;
  assign memwb_wena = back_en;
  assign retire     = memwb_valid & ~mem_busy;
  assign ctrl_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CTRL_RUN;
      ifid_valid  <= 1'b0;
      idex_valid  <= 1'b0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
    end else begin
      state <= act;
      if (act != CTRL_FREEZE) begin
        ifid_valid  <= act == CTRL_RUN ? 1'b1 : act == CTRL_STALL_LU ? ifid_valid : 1'b0;
        idex_valid  <= (act == CTRL_RUN || (act == CTRL_FLUSH && FLUSH_DEPTH == 1)) ? ifid_valid : 1'b0;
        exmem_valid <= idex_valid;
        memwb_valid <= exmem_valid;
      end
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc;
  assign stall_inc = act == CTRL_STALL_LU || act == CTRL_FREEZE;
  assign flush_inc = act == CTRL_FLUSH;
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt));
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt));
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
